pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage CPU, replacing the fixed per-stage registers (IF/ID … MEM/WB) with one generic block. It carries an arbitrary-width payload under the valid/allowin handshake and adds per-stage ready_go, a synchronous flush, and an optional two-entry skid mode. In skid mode the upstream allowin comes straight from a flop, which breaks the combinational allowin chain across stages.

## Interface
- DATA_W, 32, payload width in bits (≥1)
- SKID, 0, 0 = single register, 1 = two-entry skid buffer; any other value is an elaboration error
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream stage has a valid payload
- in_allowin  out  1  this stage accepts a payload this cycle
- in_data  in  DATA_W  upstream payload
- ready_go  in  1  this stage's logic has finished with the head entry
- flush  in  1  synchronous kill of all held entries (e.g. branch/exception)
- out_valid  out  1  head entry valid and ready_go
- out_allowin  in  1  downstream allowin
- out_data  out  DATA_W  head entry payload
- occ  out  2  entries held: 0, 1 or 2 (2 only when SKID=1)

## Operation
- in_fire = in_valid & in_allowin; out_fire = out_valid & out_allowin; out_valid = head_valid & ready_go.
- SKID=0:
  - in_allowin = !head_valid | (ready_go & out_allowin), combinational.
  - When in_allowin is high, head_valid <= in_valid. On in_fire, head_data <= in_data.
- SKID=1: three states, EMPTY, ONE and FULL. in_allowin = (state != FULL), driven directly from the state flop.
  - EMPTY: in_fire -> ONE, head <= in_data.
  - ONE:
    - out_fire only -> EMPTY.
    - in_fire only -> FULL, skid <= in_data.
    - Both -> ONE, head <= in_data.
  - FULL:
    - out_fire -> ONE, head <= skid.
    - No in_fire is possible in FULL.
- flush has the highest priority. At the next edge all valids clear: state EMPTY, occ 0. Any in_fire in the same cycle is discarded. Data registers keep their contents; their value is don't-care.
- out_data always reflects the head register. Ordering is strictly FIFO, with no reordering or duplication.
- occ: EMPTY=0, ONE=1, FULL=2. In SKID=0, occ = {1'b0, head_valid}.

## Timing
- Reset (rst low, asynchronous):
  - All valids 0, head/skid data 0, occ 0.
  - out_valid 0, out_data 0, in_allowin 1.
- Latency is 1 cycle from in_fire to out_valid, given ready_go=1.
- Sustained throughput is 1 payload/cycle in both modes while downstream is open.
- SKID=1 behaviour:
  - On a downstream stall, one extra payload is absorbed.
  - in_allowin drops in the cycle after the FULL transition.
  - in_allowin rises in the cycle after the out_fire that leaves FULL.
- ready_go low holds the head entry. out_valid stays low, and data stays stable.
- Reset asserted mid-transfer aborts the transfer immediately. Nothing is output until the first in_fire after release.
- flush together with out_fire: downstream sees the out_fire that cycle; this stage is still empty afterwards.

## Structure
- Shared package cpu_pipe_pkg holds:
  - state encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2
  - the DATA_W default constant
- One sub-module, pipe_slot: a DATA_W-bit register with load enable and asynchronous active-low clear. It is instantiated for head, and additionally for skid when SKID=1.
- The SKID branch is chosen with a generate on the parameter. The valid/allowin logic lives in the top module.

## Test plan
- Reset then stream, SKID=0 and SKID=1, DATA_W=32: 0x11, 0x22, 0x33 on consecutive cycles with out_allowin=1 and ready_go=1 -> out_data 0x11, 0x22, 0x33 on cycles 1, 2, 3; occ stays 1; in_allowin stays 1.
- Stall, SKID=1: out_allowin=0, push 0xA then 0xB -> occ=2 and in_allowin=0 on the next cycle. Then release out_allowin -> 0xA then 0xB out in order; in_allowin returns to 1 one cycle after 0xA leaves.
- Stall, SKID=0: same stimulus -> 0xB is not accepted while 0xA is held; in_allowin=0 combinationally while out_allowin=0.
- ready_go=0 for 3 cycles with head 0x5 -> out_valid 0 for 3 cycles, out_data stays 0x5; head exits on the first cycle ready_go=1.
- flush in FULL, SKID=1, with in_valid=1 carrying 0xC -> next cycle occ=0 and out_valid=0; 0xC is never emitted.
- Async reset asserted mid-cycle in FULL -> occ, out_valid and out_data go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers.
//   state_t    : occupancy state of a skid-mode stage (value equals entry count)
//   DATA_W_DEF : default payload width
package cpu_pipe_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload register with load enable and asynchronous active-low clear.
//   clk   : clock
//   rst_n : async clear, active low (contents go to 0)
//   load  : capture d on the rising edge
//   d     : next payload
//   q     : held payload
module pipe_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/allowin handshake,
// per-stage ready_go, synchronous flush and an optional two-entry skid mode.
//   clk, rst     : clock, asynchronous active-low reset
//   in_valid     : upstream payload valid
//   in_allowin   : this stage accepts a payload this cycle
//   in_data      : upstream payload
//   ready_go     : this stage is done with the head entry
//   flush        : drop every held entry at the next edge
//   out_valid    : head valid and ready_go
//   out_allowin  : downstream accepts
//   out_data     : head payload
//   occ          : number of held entries (0..2)
// With SKID=1 the upstream allowin is a pure function of the state flop, so
// the allowin path does not chain combinationally through this stage.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SKID   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_allowin,
    input  logic [DATA_W-1:0] in_data,
    input  logic              ready_go,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_allowin,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    logic              head_valid;
    logic              head_load;
    logic [DATA_W-1:0] head_d;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = head_valid & ready_go;
    assign in_fire   = in_valid & in_allowin;
    assign out_fire  = out_valid & out_allowin;

    pipe_slot #(.DATA_W(DATA_W)) u_head (
        .clk   (clk),
        .rst_n (rst),
        .load  (head_load),
        .d     (head_d),
        .q     (out_data)
    );

    generate
        if (SKID == 0) begin : g_single
            assign in_allowin = !head_valid | (ready_go & out_allowin);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    head_valid <= 1'b0;
                else if (flush)
                    head_valid <= 1'b0;
                else if (in_allowin)
                    head_valid <= in_valid;
            end

            // Flushed fires are discarded, so the data register is left alone.
            assign head_load = in_fire & !flush;
            assign head_d    = in_data;
            assign occ       = {1'b0, head_valid};
        end else if (SKID == 1) begin : g_skid
            state_t            state;
            state_t            state_nxt;
            logic              skid_load;
            logic [DATA_W-1:0] skid_q;

            pipe_slot #(.DATA_W(DATA_W)) u_skid (
                .clk   (clk),
                .rst_n (rst),
                .load  (skid_load),
                .d     (in_data),
                .q     (skid_q)
            );

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    state <= ST_EMPTY;
                else
                    state <= state_nxt;
            end

            always_comb begin
                state_nxt = state;
                head_load = 1'b0;
                skid_load = 1'b0;
                head_d    = in_data;
                if (flush) begin
                    state_nxt = ST_EMPTY;
                end else begin
                    unique case (state)
                        ST_EMPTY: begin
                            if (in_fire) begin
                                state_nxt = ST_ONE;
                                head_load = 1'b1;
                            end
                        end
                        ST_ONE: begin
                            if (in_fire && out_fire) begin
                                head_load = 1'b1;
                            end else if (in_fire) begin
                                state_nxt = ST_FULL;
                                skid_load = 1'b1;
                            end else if (out_fire) begin
                                state_nxt = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            // in_allowin is low here, so only the drain case exists.
                            if (out_fire) begin
                                state_nxt = ST_ONE;
                                head_load = 1'b1;
                                head_d    = skid_q;
                            end
                        end
                        default: state_nxt = ST_EMPTY;
                    endcase
                end
            end

            assign head_valid = (state != ST_EMPTY);
            assign in_allowin = (state != ST_FULL);
            assign occ        = state;
        end else begin : g_bad
            $error("pipe_stage_reg: SKID must be 0 or 1");
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance, directed
// vectors with literal expectations plus a FIFO-count model checked every cycle.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        iv [2];
    logic [31:0] id [2];
    logic        rg [2];
    logic        fl [2];
    logic        oa [2];
    logic        ia [2];
    logic        ov [2];
    logic [31:0] od [2];
    logic [1:0]  oc [2];

    pipe_stage_reg #(.DATA_W(32), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_allowin(ia[0]), .in_data(id[0]),
        .ready_go(rg[0]), .flush(fl[0]), .out_valid(ov[0]), .out_allowin(oa[0]),
        .out_data(od[0]), .occ(oc[0]));

    pipe_stage_reg #(.DATA_W(32), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_allowin(ia[1]), .in_data(id[1]),
        .ready_go(rg[1]), .flush(fl[1]), .out_valid(ov[1]), .out_allowin(oa[1]),
        .out_data(od[1]), .occ(oc[1]));

    int checks = 0;
    int errors = 0;
    bit started = 0;

    task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", n, act, exp);
        end
    endtask

    // Model: a FIFO of held payloads (count + array) and the last head value.
    int          mcnt  [2] = '{0, 0};
    logic [31:0] mbuf  [2][2];
    logic [31:0] mhead [2] = '{32'h0, 32'h0};

    function automatic bit m_allow(int k);
        if (k == 0) return (mcnt[0] == 0) || (rg[0] && oa[0]);
        return mcnt[1] < 2;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                mcnt[k]  = 0;
                mhead[k] = 32'h0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit infire, outfire;
                infire  = iv[k] && m_allow(k);
                outfire = (mcnt[k] > 0) && rg[k] && oa[k];
                if (fl[k]) begin
                    mcnt[k] = 0;
                end else begin
                    if (outfire) begin
                        mbuf[k][0] = mbuf[k][1];
                        mcnt[k]--;
                    end
                    if (infire) begin
                        mbuf[k][mcnt[k]] = id[k];
                        mcnt[k]++;
                    end
                    if (mcnt[k] > 0) mhead[k] = mbuf[k][0];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                cmp($sformatf("m%0d.out_valid", k), 32'(ov[k]), 32'((mcnt[k] > 0) && rg[k]));
                cmp($sformatf("m%0d.in_allowin", k), 32'(ia[k]), 32'(m_allow(k)));
                cmp($sformatf("m%0d.occ", k), 32'(oc[k]), 32'(mcnt[k]));
                cmp($sformatf("m%0d.out_data", k), od[k], mhead[k]);
            end
        end
    end

    task automatic drv(input int k, input logic v, input logic [31:0] d,
                       input logic r, input logic o, input logic f);
        iv[k] = v; id[k] = d; rg[k] = r; oa[k] = o; fl[k] = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        drv(0, 0, 0, 1, 1, 0);
        drv(1, 0, 0, 1, 1, 0);
    endtask

    initial begin
        idle_all();
        #2;
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("rst%0d.in_allowin", k), 32'(ia[k]), 32'd1);
            cmp($sformatf("rst%0d.out_valid", k), 32'(ov[k]), 32'd0);
            cmp($sformatf("rst%0d.occ", k), 32'(oc[k]), 32'd0);
            cmp($sformatf("rst%0d.out_data", k), od[k], 32'd0);
        end
        started = 1;
        @(posedge clk); #1 rst = 1'b1;
        step();

        // Stream 0x11, 0x22, 0x33 through both instances.
        for (int i = 0; i < 3; i++) begin
            logic [31:0] v;
            v = 32'h11 * (i + 1);
            drv(0, 1, v, 1, 1, 0);
            drv(1, 1, v, 1, 1, 0);
            step();
            for (int k = 0; k < 2; k++) begin
                cmp($sformatf("stream%0d.data%0d", k, i), od[k], v);
                cmp($sformatf("stream%0d.occ%0d", k, i), 32'(oc[k]), 32'd1);
                cmp($sformatf("stream%0d.allow%0d", k, i), 32'(ia[k]), 32'd1);
            end
        end
        idle_all();
        step();

        // SKID=1 stall absorbs a second payload, drains in order.
        drv(1, 1, 32'hA, 1, 0, 0); step();
        cmp("skid.occ_a", 32'(oc[1]), 32'd1);
        drv(1, 1, 32'hB, 1, 0, 0); step();
        cmp("skid.occ_full", 32'(oc[1]), 32'd2);
        cmp("skid.allow_full", 32'(ia[1]), 32'd0);
        cmp("skid.head_a", od[1], 32'hA);
        drv(1, 0, 32'h0, 1, 1, 0); step();
        cmp("skid.head_b", od[1], 32'hB);
        cmp("skid.allow_back", 32'(ia[1]), 32'd1);
        step();
        cmp("skid.drained", 32'(oc[1]), 32'd0);

        // SKID=0 stall: B refused while A held.
        drv(0, 1, 32'hA, 1, 0, 0); step();
        drv(0, 1, 32'hB, 1, 0, 0); #1;
        cmp("single.allow_stall", 32'(ia[0]), 32'd0);
        step();
        cmp("single.hold_a", od[0], 32'hA);
        drv(0, 1, 32'hB, 1, 1, 0); #1;
        cmp("single.allow_open", 32'(ia[0]), 32'd1);
        step();
        cmp("single.head_b", od[0], 32'hB);
        drv(0, 0, 32'h0, 1, 1, 0); step();

        // ready_go low holds head 0x5 for three cycles.
        drv(0, 1, 32'h5, 1, 1, 0); step();
        drv(0, 0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("rg.valid_low", 32'(ov[0]), 32'd0);
            cmp("rg.data_held", od[0], 32'h5);
        end
        drv(0, 0, 32'h0, 1, 1, 0); #1;
        cmp("rg.valid_go", 32'(ov[0]), 32'd1);
        step();
        cmp("rg.exited", 32'(oc[0]), 32'd0);

        // Flush in FULL discards both entries and the incoming 0xC.
        drv(1, 1, 32'h1, 1, 0, 0); step();
        drv(1, 1, 32'h2, 1, 0, 0); step();
        drv(1, 1, 32'hC, 1, 0, 1); step();
        cmp("flush.occ", 32'(oc[1]), 32'd0);
        cmp("flush.valid", 32'(ov[1]), 32'd0);
        drv(1, 0, 32'h0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            cmp("flush.no_c", 32'(ov[1]), 32'd0);
        end

        // Async reset mid-cycle while FULL.
        drv(1, 1, 32'h3, 1, 0, 0); step();
        drv(1, 1, 32'h4, 1, 0, 0); step();
        drv(1, 0, 32'h0, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        cmp("arst.occ", 32'(oc[1]), 32'd0);
        cmp("arst.valid", 32'(ov[1]), 32'd0);
        cmp("arst.data", od[1], 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        drv(1, 0, 32'h0, 1, 1, 0);
        step();
        cmp("arst.quiet", 32'(ov[1]), 32'd0);

        // Mixed traffic against the model.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 2; k++)
                drv(k, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            step();
        end
        idle_all();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
